// File: rtl/led_burst_ctrl.sv
// LED pattern controller: OFF / ON / BLINK / BURST-with-pause, stepped by the
// divider tick strobe, reconfigured through a valid/ready handshake.
module led_burst_ctrl #(
  parameter int PAUSE_TICKS = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_n,
  output logic             led,
  output logic             burst_done
);

  typedef enum logic [1:0] {IDLE, HI, LO, PAUSE} state_t;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  state_t           state, state_nx;
  logic [1:0]       mode_r, mode_nx;
  logic [CNT_W-1:0] n_r, n_nx;
  logic [CNT_W-1:0] remaining, rem_nx, rem_dec;
  logic [7:0]       pause_cnt, pc_nx, pc_dec;
  logic             led_nx, bd_nx;
  logic             accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode_r     <= M_OFF;
      n_r        <= '0;
      remaining  <= '0;
      pause_cnt  <= '0;
      led        <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      mode_r     <= mode_nx;
      n_r        <= n_nx;
      remaining  <= rem_nx;
      pause_cnt  <= pc_nx;
      led        <= led_nx;
      burst_done <= bd_nx;
    end
  end

  // Saturating decrements: counters never wrap below zero.
  assign rem_dec = remaining - CNT_W'(remaining != '0);
  assign pc_dec  = pause_cnt - 8'(pause_cnt != 8'd0);
  assign accept  = cfg_valid && cfg_ready;

  always_comb begin
    state_nx = state;
    mode_nx  = mode_r;
    n_nx     = n_r;
    rem_nx   = remaining;
    pc_nx    = pause_cnt;
    led_nx   = led;
    bd_nx    = 1'b0;
    if (accept) begin
      // A config wins over a same-cycle tick and silently aborts any pause.
      mode_nx = cfg_mode;
      n_nx    = cfg_n;
      case (cfg_mode)
        M_OFF:   begin state_nx = IDLE; led_nx = 1'b0; end
        M_ON:    begin state_nx = IDLE; led_nx = 1'b1; end
        M_BLINK: begin state_nx = HI;   led_nx = 1'b1; end
        default: begin
          if (cfg_n == '0) begin
            state_nx = IDLE; led_nx = 1'b0;
          end else begin
            state_nx = HI; led_nx = 1'b1; rem_nx = cfg_n;
          end
        end
      endcase
    end else if (enable && tick) begin
      case (state)
        HI: begin state_nx = LO; led_nx = 1'b0; end
        LO: begin
          if (mode_r == M_BURST) begin
            rem_nx = rem_dec;
            if (rem_dec == '0) begin
              state_nx = PAUSE;
              pc_nx    = 8'(PAUSE_TICKS);
              led_nx   = 1'b0;
              bd_nx    = 1'b1;
            end else begin
              state_nx = HI; led_nx = 1'b1;
            end
          end else begin
            state_nx = HI; led_nx = 1'b1;
          end
        end
        PAUSE: begin
          pc_nx = pc_dec;
          if (pc_dec == 8'd0) begin
            state_nx = HI; rem_nx = n_r; led_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (mode_r != M_BURST) || (state == IDLE) || (state == PAUSE);
  end

endmodule
